ctrl_regs: RTL
==============

# ctrl_regs

Parametrised control-register bank on the master byte bus: N independently addressed registers, each written from the shared master data byte when its valid strobe fires. Each write is echoed back through the standard slave message interface (have_msg/rdreq/data/len). Per-register pulse mode makes a bit field auto-clear after a programmable cycle count. It sits beside the other slave endpoints behind the command decoder and drives board-level mux, load, DAC and power-enable controls.

## Interface
- N_REGS, default 9: number of registers/channels.
- DATA_W, default 8: implemented width of each register (1..8); master_data bits above DATA_W are ignored.
- RST_VALS, default 0: N_REGS*8-bit packed reset values; register i resets to RST_VALS[i*8 +: DATA_W].
- PULSE_MASK, default 0: N_REGS bits; bit i=1 puts register i in pulse mode.
- PULSE_CYCLES, default 16: pulse length in clk cycles, ≥1.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- master_data  in  8  write byte from the command decoder.
- valid_bus  in  N_REGS  bit i = write master_data to register i this cycle.
- rdreq_bus  in  N_REGS  bit i = pop pending echo of channel i.
- have_msg_bus  out  N_REGS  bit i = echo byte pending on channel i.
- slave_data_bus  out  N_REGS*8  slice i = echo byte, zero-extended from DATA_W.
- len_bus  out  N_REGS*8  slice i = 1 while have_msg_bus[i], else 0.
- regs_out  out  N_REGS*8  slice i = live register value, zero-extended.

## Operation
- Reset (rst=1 at a clk edge, dominates all inputs): reg i = RST_VALS slice, echo bytes 0, have_msg_bus 0, pulse counters 0; hence len_bus 0, slave_data_bus 0.
- Write: valid_bus[i]=1 → reg i ← master_data[DATA_W-1:0], echo i ← same value, have_msg i ← 1. Several valid bits in one cycle are legal; all addressed registers take the same byte.
- Echo pop: rdreq_bus[i]=1 with have_msg i=1 → have_msg i ← 0; echo byte holds its value. rdreq with have_msg=0 is ignored.
- Same-cycle valid_bus[i] and rdreq_bus[i]: write wins; have_msg stays 1 with the new echo byte (the old one is overwritten, one-deep per channel).
- Write while have_msg=1 without rdreq: echo overwritten, have_msg stays 1; no overflow flag.
- Pulse mode (PULSE_MASK[i]=1): a write of a nonzero value loads counter i with PULSE_CYCLES; each cycle with counter>0 decrements it; on the cycle it decrements 1→0, reg i ← RST_VALS slice. A write during counting reloads the counter with the new value. A write of zero stores zero and clears the counter. The echo byte is the written value, not the live value.
- Normal mode (PULSE_MASK[i]=0): counter is unused and constant 0; register holds until the next write or reset.

## Timing
- Write at edge t: regs_out, slave_data_bus, have_msg_bus and len_bus update at t, visible through cycle t+1. One cycle of latency, no combinational path from valid_bus to outputs.
- Pop at edge t: have_msg_bus and len_bus drop at t.
- Pulse: nonzero value visible for exactly PULSE_CYCLES cycles after the write edge, then returns to the reset value.
- Counter width is $clog2(PULSE_CYCLES+1).
- rst asserted mid-pulse: pulse aborted, counter 0, register at its reset value on the next cycle.

## Structure
- Shared package/include: default byte width (8), default N_REGS, and the len encoding constant (1 byte).
- One sub-module, ctrl_reg_channel (register, echo byte, have_msg flag, pulse counter), instanced N_REGS times by generate. It takes its reset value and pulse-enable as parameters.
- The top level does only slicing, concatenation and zero-extension.

## Test plan
- Reset with RST_VALS slice 2 = 8'h05, DATA_W=4: rst for one edge → regs_out[23:16]=8'h05, every have_msg 0, every len 0.
- Write 8'hA7 on valid_bus[0], DATA_W=4 → next cycle regs_out[7:0]=8'h07, have_msg[0]=1, len[7:0]=1, slave_data[7:0]=8'h07. Pulse rdreq_bus[0] → have_msg[0]=0, len=0.
- valid_bus[3] and rdreq_bus[3] in the same cycle with 8'h01 → have_msg[3] stays 1, echo=8'h01.
- Pulse mode on reg 4, PULSE_CYCLES=3: write 8'h01 → reg 4 =1 for exactly 3 cycles, then 0. Rewrite 8'h01 at cycle 2 → high for 3 cycles after the rewrite edge.
- Assert rst mid-pulse and during a simultaneous write to regs 1 and 5 → all registers at reset values, no have_msg set.
- valid_bus=9'h1FF with 8'h01 → all nine registers =1 and all have_msg set. Pop channels one per cycle; each flag clears only on its own rdreq.

Source files
------------

// File: rtl/ctrl_regs_pkg.sv
// Shared constants for the control-register bank: byte width, default
// channel count and the fixed echo-message length.
package ctrl_regs_pkg;
  localparam int BYTE_W = 8;
  localparam int DEFAULT_N_REGS = 9;
  localparam logic [BYTE_W-1:0] LEN_ONE = 8'd1;
endpackage

// File: rtl/ctrl_reg_channel.sv
// One control register with its one-deep echo byte, have_msg flag and
// optional auto-clearing pulse counter.
module ctrl_reg_channel
  import ctrl_regs_pkg::*;
#(
  parameter int DATA_W = BYTE_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit PULSE_EN = 1'b0,
  parameter int PULSE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wdata,
  input  logic              valid,
  input  logic              rdreq,
  output logic              have_msg,
  output logic [DATA_W-1:0] echo,
  output logic [DATA_W-1:0] value
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= RST_VAL;
      echo     <= '0;
      have_msg <= 1'b0;
      cnt      <= '0;
    end else if (valid) begin
      // A write beats a same-cycle pop and restarts any pulse in flight.
      value    <= wdata;
      echo     <= wdata;
      have_msg <= 1'b1;
      if (PULSE_EN) cnt <= (wdata != '0) ? CNT_LOAD : '0;
    end else begin
      if (rdreq) have_msg <= 1'b0;
      if (PULSE_EN && cnt != '0) begin
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) value <= RST_VAL;
      end
    end
  end

endmodule

// File: rtl/ctrl_regs.sv
// Bank of N_REGS byte-bus control registers with per-channel write echo;
// only slices, zero-extends and concatenates the channel instances.
module ctrl_regs
  import ctrl_regs_pkg::*;
#(
  parameter int N_REGS = DEFAULT_N_REGS,
  parameter int DATA_W = BYTE_W,
  parameter logic [N_REGS*8-1:0] RST_VALS = '0,
  parameter logic [N_REGS-1:0] PULSE_MASK = '0,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          master_data,
  input  logic [N_REGS-1:0]   valid_bus,
  input  logic [N_REGS-1:0]   rdreq_bus,
  output logic [N_REGS-1:0]   have_msg_bus,
  output logic [N_REGS*8-1:0] slave_data_bus,
  output logic [N_REGS*8-1:0] len_bus,
  output logic [N_REGS*8-1:0] regs_out
);

  logic [DATA_W-1:0] wdata;
  logic              unused_master_data;

  assign wdata = master_data[DATA_W-1:0];
  assign unused_master_data = ^master_data;

  for (genvar i = 0; i < N_REGS; i++) begin : g_ch
    logic [DATA_W-1:0] echo;
    logic [DATA_W-1:0] value;

    ctrl_reg_channel #(
      .DATA_W      (DATA_W),
      .RST_VAL     (RST_VALS[i*8 +: DATA_W]),
      .PULSE_EN    (PULSE_MASK[i]),
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wdata   (wdata),
      .valid   (valid_bus[i]),
      .rdreq   (rdreq_bus[i]),
      .have_msg(have_msg_bus[i]),
      .echo    (echo),
      .value   (value)
    );

    assign slave_data_bus[i*8 +: 8] = BYTE_W'(echo);
    assign regs_out[i*8 +: 8]       = BYTE_W'(value);
    assign len_bus[i*8 +: 8]        = have_msg_bus[i] ? LEN_ONE : '0;
  end

endmodule
